// File: rtl/intersection_scheduler.sv
// Right-of-way scheduler for the highway / country road intersection.
// The highway rests on green. A latched country-road request walks the grant
// through yellow and all-red to the country road, then back the same way.
// All phase timing comes from a single 8-bit down-counter.
module intersection_scheduler #(
  parameter int T_HG_MIN = 15,
  parameter int T_CG_MIN = 5,
  parameter int T_CG_MAX = 15,
  parameter int T_Y      = 3,
  parameter int T_AR     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       car_c,
  output logic [2:0] led_highway,
  output logic [2:0] led_country,
  output logic [2:0] phase,
  output logic       cycle_done
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
  } state_e;

  localparam logic [2:0] LED_GREEN  = 3'b001;
  localparam logic [2:0] LED_YELLOW = 3'b010;
  localparam logic [2:0] LED_RED    = 3'b100;

  // Counter load values: each state lasts (load + 1) cycles.
  localparam logic [7:0] LD_HG = 8'(T_HG_MIN - 1);
  localparam logic [7:0] LD_Y  = 8'(T_Y - 1);
  localparam logic [7:0] LD_AR = 8'(T_AR - 1);
  localparam logic [7:0] LD_CG = 8'(T_CG_MAX - 1);
  // Country green has run at least T_CG_MIN cycles once cnt drops to this.
  localparam logic [7:0] CG_MIN_MET = 8'(T_CG_MAX - T_CG_MIN);

  // The state register is kept at its raw width so the unused codes 6 and 7
  // stay representable and can be steered back to a safe all-red phase.
  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_q, req_d;
  logic       cycle_done_q, cycle_done_d;
  logic       cnt_zero;

  assign cnt_zero = (cnt_q == 8'd0);

  // Next state and counter: load on every transition, else count down to 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 8'd1;
    case (state_q)
      HG: begin
        if (cnt_zero && req_q) begin
          state_d = HY;
          cnt_d   = LD_Y;
        end
      end
      HY: begin
        if (cnt_zero) begin
          state_d = AR1;
          cnt_d   = LD_AR;
        end
      end
      AR1: begin
        if (cnt_zero) begin
          state_d = CG;
          cnt_d   = LD_CG;
        end
      end
      CG: begin
        if (cnt_zero || (!car_c && (cnt_q <= CG_MIN_MET))) begin
          state_d = CY;
          cnt_d   = LD_Y;
        end
      end
      CY: begin
        if (cnt_zero) begin
          state_d = AR2;
          cnt_d   = LD_AR;
        end
      end
      AR2: begin
        if (cnt_zero) begin
          state_d = HG;
          cnt_d   = LD_HG;
        end
      end
      default: begin
        state_d = AR2;
        cnt_d   = LD_AR;
      end
    endcase
  end

  // Request latch: set by car_c outside country green, cleared on entry to it.
  always_comb begin
    req_d = req_q;
    if (car_c && (state_q != CG)) begin
      req_d = 1'b1;
    end
    if ((state_d == CG) && (state_q != CG)) begin
      req_d = 1'b0;
    end
  end

  // Completion pulse: flags the edge where the grant returns to the highway.
  always_comb begin
    cycle_done_d = (state_q == AR2) && (state_d == HG);
  end

  // State, counter, request and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HG;
      cnt_q        <= LD_HG;
      req_q        <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  // Moore light decode; anything unexpected shows red on both heads.
  always_comb begin
    led_highway = LED_RED;
    led_country = LED_RED;
    case (state_q)
      HG: led_highway = LED_GREEN;
      HY: led_highway = LED_YELLOW;
      CG: led_country = LED_GREEN;
      CY: led_country = LED_YELLOW;
      default: begin
        led_highway = LED_RED;
        led_country = LED_RED;
      end
    endcase
  end

  assign phase      = state_q;
  assign cycle_done = cycle_done_q;

endmodule
